// File: rtl/alu_req_arbiter_if.sv
// Bus bundle between two ALU clients, the response consumer, the shared ALU and
// alu_req_arbiter. The slave modport is the arbiter's view; master is the environment's.
interface alu_req_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [1:0]       rsp_op;
    logic [WIDTH:0]   rsp_y;
    logic             rsp_eq;
    logic             rsp_gt;
    logic             rsp_lt;

    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH:0]   alu_y_addsub;
    logic [WIDTH-1:0] alu_y_and;
    logic             alu_eq;
    logic             alu_gt;
    logic             alu_lt;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_op, rsp_y, rsp_eq, rsp_gt, rsp_lt,
        input  rsp_ready,
        output alu_sel, alu_a, alu_b,
        input  alu_y_addsub, alu_y_and, alu_eq, alu_gt, alu_lt
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_op, rsp_y, rsp_eq, rsp_gt, rsp_lt,
        output rsp_ready,
        input  alu_sel, alu_a, alu_b,
        output alu_y_addsub, alu_y_and, alu_eq, alu_gt, alu_lt
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// holds the ALU inputs for SETTLE_CYCLES, then returns a tagged valid/ready response.
module alu_req_arbiter #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_req_arbiter_if.slave   bus,
    output logic               busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD  = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [1:0]       rsp_op_q, rsp_op_d;
    logic [WIDTH:0]   rsp_y_q, rsp_y_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       req_ready;
    logic [1:0]       req_op [2];
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];
    logic             accept;
    logic             acc_id;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_op[0] = bus.req0_op;
    assign req_op[1] = bus.req1_op;
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    // A requester wins when it is alone, or when the other one was served last.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign grant[gi]     = req_valid[gi] &
                                   (~req_valid[1-gi] | (last_grant_q != 1'(gi)));
            assign req_ready[gi] = (state_q == ST_IDLE) & grant[gi];
        end
    endgenerate

    assign accept = |req_ready;
    assign acc_id = req_ready[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_op_d     = rsp_op_q;
        rsp_y_d      = rsp_y_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        lt_d         = lt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d        = req_op[acc_id];
                    a_d          = req_a[acc_id];
                    b_d          = req_b[acc_id];
                    id_d         = acc_id;
                    last_grant_d = acc_id;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_op_d = sel_q;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    case (sel_q)
                        2'b10: begin
                            rsp_y_d = '0;
                            eq_d    = bus.alu_eq;
                            gt_d    = bus.alu_gt;
                            lt_d    = bus.alu_lt;
                        end
                        2'b11:   rsp_y_d = {1'b0, bus.alu_y_and};
                        default: rsp_y_d = bus.alu_y_addsub;
                    endcase
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset drops any in-flight operation and re-arms requester 0 as first winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            sel_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_op_q     <= '0;
            rsp_y_q      <= '0;
            eq_q         <= 1'b0;
            gt_q         <= 1'b0;
            lt_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_op_q     <= rsp_op_d;
            rsp_y_q      <= rsp_y_d;
            eq_q         <= eq_d;
            gt_q         <= gt_d;
            lt_q         <= lt_d;
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_eq     = eq_q;
    assign bus.rsp_gt     = gt_q;
    assign bus.rsp_lt     = lt_q;
    assign bus.alu_sel    = sel_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign busy           = (state_q != ST_IDLE);
endmodule
